// File: rtl/wish_pack.sv
// Packs NUM_PACK narrow Wishbone beats into one wide word; a word is registered on the edge its last beat is accepted.
// Only a completing beat stalls, and only while the output register is still held by the sink.
module wish_pack #(
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_PACK      = 4,
  parameter int TGC_WIDTH     = 2,
  parameter bit LITTLE_ENDIAN = 1'b0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           s_cyc_i,
  input  logic                           s_stb_i,
  input  logic [DATA_WIDTH-1:0]          s_dat_i,
  input  logic [TGC_WIDTH-1:0]           s_tgc_i,
  output logic                           s_ack_o,
  output logic                           s_stall_o,
  output logic                           d_cyc_o,
  output logic                           d_stb_o,
  output logic [DATA_WIDTH*NUM_PACK-1:0] d_dat_o,
  output logic [NUM_PACK-1:0]            d_sel_o,
  output logic [TGC_WIDTH-1:0]           d_tgc_o,
  input  logic                           d_ack_i,
  output logic                           err_o
);

  localparam int              CW        = $clog2(NUM_PACK);
  localparam int              WW        = DATA_WIDTH * NUM_PACK;
  localparam logic [CW-1:0]   LAST_LANE = CW'(NUM_PACK - 1);

  logic [CW-1:0]        r_cnt;
  logic [WW-1:0]        r_acc_dat;
  logic [NUM_PACK-1:0]  r_acc_sel;
  logic                 r_first_tag;
  logic                 r_out_vld;
  logic [WW-1:0]        r_d_dat;
  logic [NUM_PACK-1:0]  r_d_sel;
  logic [TGC_WIDTH-1:0] r_d_tgc;
  logic                 r_s_ack;
  logic                 r_err;

  logic                 w_accept;
  logic                 w_misfirst;
  logic [CW-1:0]        w_k;
  logic                 w_complete;
  logic                 w_first_tag;
  logic [WW-1:0]        w_new_dat;
  logic [NUM_PACK-1:0]  w_new_sel;

  // Stall uses the raw lane count, so a misplaced first beat may be held back conservatively.
  assign s_stall_o  = r_out_vld & ~d_ack_i & ((r_cnt == LAST_LANE) | s_tgc_i[1]);
  assign w_accept   = s_cyc_i & s_stb_i & ~s_stall_o;
  assign w_misfirst = w_accept & s_tgc_i[0] & (r_cnt != '0);
  assign w_k        = w_misfirst ? '0 : r_cnt;
  assign w_complete = w_accept & ((w_k == LAST_LANE) | s_tgc_i[1]);
  assign w_first_tag = (w_k == '0) ? s_tgc_i[0] : r_first_tag;

  always_comb begin
    w_new_dat = w_misfirst ? '0 : r_acc_dat;
    w_new_sel = w_misfirst ? '0 : r_acc_sel;
    for (int i = 0; i < NUM_PACK; i++) begin
      if ((LITTLE_ENDIAN ? CW'(i) : CW'(NUM_PACK - 1 - i)) == w_k) begin
        w_new_dat[i*DATA_WIDTH +: DATA_WIDTH] = s_dat_i;
        w_new_sel[i]                          = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt       <= '0;
      r_acc_dat   <= '0;
      r_acc_sel   <= '0;
      r_first_tag <= 1'b0;
    end else if (w_accept) begin
      r_first_tag <= w_first_tag;
      if (w_complete) begin
        r_cnt     <= '0;
        r_acc_dat <= '0;
        r_acc_sel <= '0;
      end else begin
        r_cnt     <= w_k + 1'b1;
        r_acc_dat <= w_new_dat;
        r_acc_sel <= w_new_sel;
      end
    end
  end

  // A completion may overwrite a word retiring on the same edge, so there is no bubble.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_out_vld <= 1'b0;
      r_d_dat   <= '0;
      r_d_sel   <= '0;
      r_d_tgc   <= '0;
    end else if (w_complete) begin
      r_out_vld <= 1'b1;
      r_d_dat   <= w_new_dat;
      r_d_sel   <= w_new_sel;
      r_d_tgc   <= {s_tgc_i[TGC_WIDTH-1:1], w_first_tag};
    end else if (r_out_vld && d_ack_i) begin
      r_out_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_s_ack <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_s_ack <= w_accept;
      r_err   <= w_misfirst;
    end
  end

  assign s_ack_o = r_s_ack;
  assign err_o   = r_err;
  assign d_cyc_o = r_out_vld;
  assign d_stb_o = r_out_vld;
  assign d_dat_o = r_d_dat;
  assign d_sel_o = r_d_sel;
  assign d_tgc_o = r_d_tgc;

endmodule

// File: tb/tb_wish_pack.sv
// Directed bench for wish_pack: one big-endian and one little-endian instance share the same stimulus.
module tb_wish_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_cyc, s_stb, d_ack;
  logic [7:0]  s_dat;
  logic [1:0]  s_tgc;

  logic        s_ack0, s_stall0, d_cyc0, d_stb0, err0;
  logic [31:0] d_dat0;
  logic [3:0]  d_sel0;
  logic [1:0]  d_tgc0;
  logic        s_ack1, s_stall1, d_cyc1, d_stb1, err1;
  logic [31:0] d_dat1;
  logic [3:0]  d_sel1;
  logic [1:0]  d_tgc1;

  int n_tests = 0;
  int n_fail  = 0;
  int ack0 = 0, ack1 = 0, errc0 = 0, errc1 = 0;
  int stall_hi = 0, stall_bad = 0;
  bit bp_on = 1'b0;
  logic [37:0] q0[$];
  logic [37:0] q1[$];

  always #5 clk = ~clk;

  wish_pack #(.DATA_WIDTH(8), .NUM_PACK(4), .TGC_WIDTH(2), .LITTLE_ENDIAN(1'b0)) u_be (
    .clk_i(clk), .rst_i(rst_n), .s_cyc_i(s_cyc), .s_stb_i(s_stb), .s_dat_i(s_dat), .s_tgc_i(s_tgc),
    .s_ack_o(s_ack0), .s_stall_o(s_stall0), .d_cyc_o(d_cyc0), .d_stb_o(d_stb0), .d_dat_o(d_dat0),
    .d_sel_o(d_sel0), .d_tgc_o(d_tgc0), .d_ack_i(d_ack), .err_o(err0)
  );

  wish_pack #(.DATA_WIDTH(8), .NUM_PACK(4), .TGC_WIDTH(2), .LITTLE_ENDIAN(1'b1)) u_le (
    .clk_i(clk), .rst_i(rst_n), .s_cyc_i(s_cyc), .s_stb_i(s_stb), .s_dat_i(s_dat), .s_tgc_i(s_tgc),
    .s_ack_o(s_ack1), .s_stall_o(s_stall1), .d_cyc_o(d_cyc1), .d_stb_o(d_stb1), .d_dat_o(d_dat1),
    .d_sel_o(d_sel1), .d_tgc_o(d_tgc1), .d_ack_i(d_ack), .err_o(err1)
  );

  // Mid-cycle observer: words are captured when they will retire on the next rising edge.
  always @(negedge clk) begin
    if (s_ack0) ack0 <= ack0 + 1;
    if (s_ack1) ack1 <= ack1 + 1;
    if (err0)   errc0 <= errc0 + 1;
    if (err1)   errc1 <= errc1 + 1;
    if (d_stb0 && d_ack) q0.push_back({d_tgc0, d_sel0, d_dat0});
    if (d_stb1 && d_ack) q1.push_back({d_tgc1, d_sel1, d_dat1});
    if (bp_on && s_stall0) begin
      stall_hi <= stall_hi + 1;
      if (s_dat !== 8'h08) stall_bad <= stall_bad + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pop_word(input string tag, input logic [37:0] e0, input logic [37:0] e1);
    logic [37:0] g;
    g = '1;
    if (q0.size() > 0) g = q0.pop_front();
    check({tag, "_be"}, 64'(g), 64'(e0));
    g = '1;
    if (q1.size() > 0) g = q1.pop_front();
    check({tag, "_le"}, 64'(g), 64'(e1));
  endtask

  task automatic send_beat(input logic [7:0] d, input logic [1:0] t);
    int n;
    n = 0;
    s_cyc = 1'b1;
    s_stb = 1'b1;
    s_dat = d;
    s_tgc = t;
    @(negedge clk);
    while (s_stall0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) check("stall_timeout", 64'(1), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_cyc = 1'b0;
    s_stb = 1'b0;
    s_dat = '0;
    s_tgc = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, a1, e0, e1;
    rst_n = 1'b0;
    s_cyc = 1'b0; s_stb = 1'b0; s_dat = '0; s_tgc = '0; d_ack = 1'b1;
    #2;
    check("rst_be", 64'({s_ack0, s_stall0, d_cyc0, d_stb0, d_dat0, d_sel0, d_tgc0, err0}), 64'(0));
    check("rst_le", 64'({s_ack1, s_stall1, d_cyc1, d_stb1, d_dat1, d_sel1, d_tgc1, err1}), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // full word
    a0 = ack0; a1 = ack1;
    send_beat(8'h11, 2'b01);
    send_beat(8'h22, 2'b00);
    send_beat(8'h33, 2'b00);
    send_beat(8'h44, 2'b10);
    idle(4);
    check("full_acks_be", 64'(ack0 - a0), 64'(4));
    check("full_acks_le", 64'(ack1 - a1), 64'(4));
    pop_word("full", {2'b11, 4'b1111, 32'h11223344}, {2'b11, 4'b1111, 32'h44332211});
    check("full_extra", 64'(q0.size() + q1.size()), 64'(0));

    // partial word flushed by last tag
    send_beat(8'hAA, 2'b01);
    send_beat(8'hBB, 2'b10);
    idle(4);
    pop_word("partial", {2'b11, 4'b1100, 32'hAABB0000}, {2'b11, 4'b0011, 32'h0000BBAA});
    check("partial_extra", 64'(q0.size() + q1.size()), 64'(0));

    // backpressure: sink holds ack low for 6 cycles after first strobe
    a0 = ack0;
    d_ack = 1'b0;
    bp_on = 1'b1;
    fork
      begin
        send_beat(8'h01, 2'b01);
        for (int i = 2; i <= 7; i++) send_beat(8'(i), 2'b00);
        send_beat(8'h08, 2'b10);
        idle(0);
      end
      begin
        int n;
        n = 0;
        @(negedge clk);
        while (!d_stb0 && n < 100) begin
          n++;
          @(negedge clk);
        end
        if (n >= 100) check("bp_stb_timeout", 64'(1), 64'(0));
        repeat (6) @(posedge clk);
        #1 d_ack = 1'b1;
      end
    join
    idle(6);
    bp_on = 1'b0;
    check("bp_stall_cycles", 64'(stall_hi), 64'(3));
    check("bp_stall_other", 64'(stall_bad), 64'(0));
    check("bp_acks", 64'(ack0 - a0), 64'(8));
    pop_word("bp_w0", {2'b01, 4'b1111, 32'h01020304}, {2'b01, 4'b1111, 32'h04030201});
    pop_word("bp_w1", {2'b10, 4'b1111, 32'h05060708}, {2'b10, 4'b1111, 32'h08070605});
    check("bp_extra", 64'(q0.size() + q1.size()), 64'(0));

    // misplaced first beat discards the partial word
    a0 = ack0; e0 = errc0; e1 = errc1;
    send_beat(8'h01, 2'b01);
    send_beat(8'h02, 2'b00);
    send_beat(8'h03, 2'b01);
    send_beat(8'h04, 2'b00);
    send_beat(8'h05, 2'b00);
    send_beat(8'h06, 2'b10);
    idle(4);
    check("mis_err_be", 64'(errc0 - e0), 64'(1));
    check("mis_err_le", 64'(errc1 - e1), 64'(1));
    check("mis_acks", 64'(ack0 - a0), 64'(6));
    pop_word("mis", {2'b11, 4'b1111, 32'h03040506}, {2'b11, 4'b1111, 32'h06050403});
    check("mis_extra", 64'(q0.size() + q1.size()), 64'(0));

    // asynchronous reset mid-word
    e0 = errc0;
    send_beat(8'h01, 2'b01);
    send_beat(8'h02, 2'b00);
    s_cyc = 1'b0; s_stb = 1'b0; s_dat = '0; s_tgc = '0;
    check("pre_rst_ack", 64'(s_ack0), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("arst_be", 64'({s_ack0, s_stall0, d_cyc0, d_stb0, d_dat0, d_sel0, d_tgc0, err0}), 64'(0));
    check("arst_le", 64'({s_ack1, s_stall1, d_cyc1, d_stb1, d_dat1, d_sel1, d_tgc1, err1}), 64'(0));
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_beat(8'h55, 2'b01);
    send_beat(8'h66, 2'b00);
    send_beat(8'h77, 2'b00);
    send_beat(8'h88, 2'b10);
    idle(4);
    check("post_rst_err", 64'(errc0 - e0), 64'(0));
    pop_word("post_rst", {2'b11, 4'b1111, 32'h55667788}, {2'b11, 4'b1111, 32'h88776655});
    check("post_rst_extra", 64'(q0.size() + q1.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wish_pack.md
Name: wish_pack

Overview:
- Wishbone stream width-aggregator: collects NUM_PACK narrow DATA_WIDTH beats into one wide word, and passes packet tags (first/last) through.
- Sits directly upstream of wish_unpack; its output bus matches wish_unpack's slave side.
- Packets whose last beat leaves a word partially filled are flushed zero-padded, with a lane-valid mask.

Parameters:
DATA_WIDTH, 8, width of one narrow input beat
NUM_PACK, 4, beats per output word (>=2)
TGC_WIDTH, 2, tag width (>=2); bit0 = first-of-packet, bit1 = last-of-packet
LITTLE_ENDIAN, 0, 0: first beat in most-significant lane; 1: first beat in lane 0

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
s_cyc_i  in  1  source cycle
s_stb_i  in  1  source strobe
s_dat_i  in  DATA_WIDTH  narrow beat
s_tgc_i  in  TGC_WIDTH  beat tags
s_ack_o  out  1  beat acknowledge
s_stall_o  out  1  source stall
d_cyc_o  out  1  sink cycle
d_stb_o  out  1  sink strobe
d_dat_o  out  DATA_WIDTH*NUM_PACK  packed word
d_sel_o  out  NUM_PACK  lane valid mask; bit i marks d_dat_o[i*DATA_WIDTH +: DATA_WIDTH]
d_tgc_o  out  TGC_WIDTH  word tags
d_ack_i  in  1  sink acknowledge
err_o  out  1  one-cycle pulse on protocol error

Behaviour:
- Reset (rst_i=0, asynchronous): s_ack_o, s_stall_o, d_cyc_o, d_stb_o, err_o = 0; d_dat_o, d_sel_o, d_tgc_o = 0; accumulator and lane count cleared. A partial word in flight is discarded.
- Datapath: accumulator (lane count cnt 0..NUM_PACK-1, data, mask, tags) feeding a single output register (out_valid).
- Beat accepted when s_cyc_i & s_stb_i & ~s_stall_o at a rising edge.
  - s_ack_o is registered: exactly one 1-cycle pulse, in the cycle after each accepted beat.
- Lane placement: beat k (k = cnt) goes to lane k if LITTLE_ENDIAN=1, else lane NUM_PACK-1-k. The matching d_sel_o bit is set.
- Word completes on acceptance of a beat where cnt==NUM_PACK-1 or s_tgc_i[1]=1. On completion:
  - Accumulator plus the current beat transfer to the output register the same edge; out_valid=1; cnt returns to 0.
  - Unfilled lanes are 0; their sel bits are 0.
- Tags:
  - d_tgc_o[0] = s_tgc_i[0] of the word's first beat.
  - d_tgc_o[1] = s_tgc_i[1] of the completing beat.
  - Bits TGC_WIDTH-1:2 come from the completing beat.
- Output handshake:
  - d_cyc_o = d_stb_o = out_valid.
  - d_dat_o, d_sel_o and d_tgc_o are held stable while out_valid=1.
  - Word retires at an edge with d_ack_i=1. d_ack_i is ignored while out_valid=0.
  - Retire and new completion in the same edge: the new word loads with no bubble; out_valid stays 1.
- Stall: s_stall_o = out_valid & ~d_ack_i & ((cnt==NUM_PACK-1) | s_tgc_i[1]). This is combinational, so non-completing beats keep flowing while the sink is busy.
- Sustained throughput: one beat per cycle when d_ack_i returns the cycle after strobe.
- Misplaced first: beat with s_tgc_i[0]=1 accepted while cnt!=0.
  - Prior partial lanes are discarded and err_o pulses 1 cycle.
  - The beat starts a new word in lane position 0.
- Beats with s_cyc_i=0 are ignored. Dropping s_cyc_i mid-word does not clear the accumulator.

Test Plan (DATA_WIDTH=8, NUM_PACK=4):
- LE=0; beats 0x11(first),0x22,0x33,0x44(last), d_ack_i tied 1 -> one word 0x11223344, d_sel_o=4'b1111, d_tgc_o=2'b11; exactly 4 s_ack_o pulses.
- LE=1; same beats -> d_dat_o=0x44332211, sel 4'b1111.
- Partial: 0xAA(first),0xBB(last) -> LE=0: 0xAABB0000, sel 4'b1100. LE=1: 0x0000BBAA, sel 4'b0011. d_tgc_o=2'b11 in both.
- Backpressure: 8 continuous beats 0x01..0x08, d_ack_i held 0 for 6 cycles after first d_stb_o -> s_stall_o high only while 0x08 is presented. Words 0x01020304 then 0x05060708 are delivered in order with no loss or duplication.
- Reset mid-word: rst_i low for 1 cycle after 0x01,0x02 accepted -> all outputs 0 asynchronously. Subsequent 0x55..0x88 yields 0x55667788.
- Misplaced first: 0x01(first),0x02,0x03(first),0x04,0x05,0x06(last) -> err_o pulses once; output 0x03040506, tgc 2'b11.
